// File: rtl/lynx_bfm_pkg.sv
// Shared lynx sink definitions: FSM states, error-bit positions and the
// helper that locates each flit field inside a WIDTH-bit word.
package lynx_bfm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL,
        ST_DONE
    } state_t;

    localparam int ERR_DST  = 0;
    localparam int ERR_SRC  = 1;
    localparam int ERR_ID   = 2;
    localparam int ERR_SEQ  = 3;
    localparam int ERR_BITS = 4;
    localparam int ID_WIDTH = 8;

    typedef struct packed {
        int src_lsb;
        int dst_lsb;
        int id_lsb;
        int data_width;
    } field_pos_t;

    // Flit layout, MSB first: src (A bits), dst (A bits), id (8 bits), data counter.
    function automatic field_pos_t field_pos(input int width, input int addr_width);
        field_pos_t p;
        p.src_lsb    = width - addr_width;
        p.dst_lsb    = width - 2 * addr_width;
        p.id_lsb     = width - 2 * addr_width - ID_WIDTH;
        p.data_width = width - 2 * addr_width - ID_WIDTH;
        return p;
    endfunction

endpackage

// File: rtl/lynx_ora_checker_if.sv
// Flit handshake between a lynx router port and the sink attached to it.
interface lynx_ora_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i0_data_in;
    logic             i0_valid_in;
    logic             i0_ready_out;

    modport master (
        output i0_data_in,
        output i0_valid_in,
        input  i0_ready_out
    );

    modport slave (
        input  i0_data_in,
        input  i0_valid_in,
        output i0_ready_out
    );
endinterface

// File: rtl/lynx_ora_checker.sv
// Traffic sink for the lynx NoC: accepts flits from one legal sender and checks
// routing, source id and sequence continuity, counting every failing flit.
module lynx_ora_checker
    import lynx_bfm_pkg::*;
#(
    parameter int                      WIDTH        = 32,
    parameter int                      N            = 16,
    parameter int                      N_ADDR_WIDTH = $clog2(N),
    parameter logic [7:0]              SINK_ID      = 8'd0,
    parameter logic [N_ADDR_WIDTH-1:0] NODE         = N_ADDR_WIDTH'(15),
    parameter logic [N_ADDR_WIDTH-1:0] EXP_SRC      = '0,
    parameter logic [7:0]              EXP_ID       = 8'd0,
    parameter int                      NUM_EXPECTED = 0,
    parameter int                      THROTTLE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    lynx_ora_checker_if.slave   i0,
    output logic [31:0]         rx_count,
    output logic [15:0]         err_count,
    output logic                err_flag,
    output logic [ERR_BITS-1:0] last_err,
    output logic                done
);

    localparam field_pos_t  POS        = field_pos(WIDTH, N_ADDR_WIDTH);
    localparam int          A          = N_ADDR_WIDTH;
    localparam int          DW         = POS.data_width;
    localparam logic [31:0] NUM_EXP_W  = 32'(NUM_EXPECTED);
    localparam logic [31:0] THROTTLE_W = 32'(THROTTLE);

    if (DW < 1) begin : g_bad_width
        $error("lynx_ora_checker sink %0d: WIDTH leaves no room for the data counter", SINK_ID);
    end
    if (int'(NODE) >= N || int'(EXP_SRC) >= N) begin : g_bad_node
        $error("lynx_ora_checker sink %0d: router index out of range", SINK_ID);
    end

    state_t                state;
    logic                  ready;
    logic [DW-1:0]         exp_seq;
    logic [31:0]           thr_cnt;
    logic [31:0]           rx_next;
    logic                  accept;
    logic                  thr_hit;
    logic                  done_hit;
    logic [ERR_BITS-1:0]   mismatch;

    logic [A-1:0]          f_src;
    logic [A-1:0]          f_dst;
    logic [ID_WIDTH-1:0]   f_id;
    logic [DW-1:0]         f_data;

    assign f_src  = i0.i0_data_in[POS.src_lsb +: A];
    assign f_dst  = i0.i0_data_in[POS.dst_lsb +: A];
    assign f_id   = i0.i0_data_in[POS.id_lsb +: ID_WIDTH];
    assign f_data = i0.i0_data_in[DW-1:0];

    // ready is only ever high in RUN, so it alone qualifies an accept.
    assign accept   = ready & i0.i0_valid_in;
    assign rx_next  = rx_count + 32'd1;
    assign thr_hit  = (THROTTLE > 0) && (thr_cnt + 32'd1 == THROTTLE_W);
    assign done_hit = (NUM_EXPECTED > 0) && (rx_next == NUM_EXP_W);

    assign i0.i0_ready_out = ready;

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        mismatch          = '0;
        mismatch[ERR_DST] = (f_dst != NODE);
        mismatch[ERR_SRC] = (f_src != EXP_SRC);
        mismatch[ERR_ID]  = (f_id != EXP_ID);
        mismatch[ERR_SEQ] = (f_data != exp_seq);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ready     <= 1'b0;
            rx_count  <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
            last_err  <= '0;
            done      <= 1'b0;
            exp_seq   <= DW'(1);
            thr_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
                ST_RUN: begin
                    if (accept) begin
                        rx_count <= rx_next;
                        // Resynchronise on every flit so a single drop costs one error.
                        exp_seq  <= f_data + DW'(1);
                        if (|mismatch) begin
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                            err_flag <= 1'b1;
                            last_err <= mismatch;
                        end
                        if (THROTTLE > 0) thr_cnt <= thr_hit ? '0 : thr_cnt + 32'd1;
                        if (done_hit) begin
                            state <= ST_DONE;
                            ready <= 1'b0;
                            done  <= 1'b1;
                        end else if (thr_hit) begin
                            state <= ST_STALL;
                            ready <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
                ST_DONE: begin
                    ready <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lynx_ora_checker.sv
// Randomised and directed bench for lynx_ora_checker: four sinks with different
// throttle/done settings, each shadowed by a transaction-level model.
module tb_lynx_ora_checker;

    localparam int          NDUT   = 4;
    localparam int          TH_TAB [NDUT] = '{0, 2, 0, 1};
    localparam int          NE_TAB [NDUT] = '{0, 0, 3, 3};
    localparam logic [3:0]  NODE_P = 4'd15;
    localparam logic [3:0]  SRC_P  = 4'd3;
    localparam logic [7:0]  ID_P   = 8'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_d  [NDUT];
    logic        valid_d [NDUT];
    logic [31:0] rx_q    [NDUT];
    logic [15:0] err_q   [NDUT];
    logic        flag_q  [NDUT];
    logic [3:0]  last_q  [NDUT];
    logic        done_q  [NDUT];
    logic        rdy_q   [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        lynx_ora_checker_if #(.WIDTH(32)) bus ();
        assign bus.i0_data_in  = data_d[g];
        assign bus.i0_valid_in = valid_d[g];
        assign rdy_q[g]        = bus.i0_ready_out;

        lynx_ora_checker #(
            .WIDTH(32), .N(16), .SINK_ID(8'(g)), .NODE(NODE_P), .EXP_SRC(SRC_P),
            .EXP_ID(ID_P), .NUM_EXPECTED(NE_TAB[g]), .THROTTLE(TH_TAB[g])
        ) dut (
            .clk(clk), .rst(rst), .i0(bus),
            .rx_count(rx_q[g]), .err_count(err_q[g]), .err_flag(flag_q[g]),
            .last_err(last_q[g]), .done(done_q[g])
        );
    end

    // Transaction-level view of one sink: what it has seen and whether it will take the next flit.
    typedef struct {
        int unsigned rx;
        int unsigned err;
        bit          flag;
        bit [3:0]    last;
        bit [15:0]   seq;
        bit          rdy;
        bit          done;
        int          acc;
    } model_t;

    model_t m [NDUT];
    bit [15:0] snd [NDUT];

    function automatic model_t model_reset();
        model_t r;
        r.rx = 0; r.err = 0; r.flag = 0; r.last = 0; r.seq = 16'd1;
        r.rdy = 0; r.done = 0; r.acc = 0;
        return r;
    endfunction

    function automatic model_t model_step(model_t s, bit v, bit [31:0] f, int th, int ne);
        model_t   r;
        bit [3:0] mask;
        r = s;
        if (s.rdy && v) begin
            mask = {f[15:0] != s.seq, f[23:16] != ID_P, f[31:28] != SRC_P, f[27:24] != NODE_P};
            r.rx  = s.rx + 1;
            r.seq = f[15:0] + 16'd1;
            if (mask != 4'd0) begin
                if (s.err < 65535) r.err = s.err + 1;
                r.flag = 1'b1;
                r.last = mask;
            end
            r.acc = s.acc + 1;
            if (ne > 0 && r.rx == ne) begin
                r.done = 1'b1;
                r.rdy  = 1'b0;
            end else if (th > 0 && r.acc == th) begin
                r.acc = 0;
                r.rdy = 1'b0;
            end
        end else if (!s.done) begin
            r.rdy = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] mk(logic [3:0] src, logic [3:0] dst, logic [7:0] id, logic [15:0] d);
        return {src, dst, id, d};
    endfunction

    function automatic logic [31:0] good(logic [15:0] d);
        return mk(SRC_P, NODE_P, ID_P, d);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NDUT; i++)
                m[i] = model_step(m[i], valid_d[i], data_d[i], TH_TAB[i], NE_TAB[i]);
        end
        #1;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
            m[i]       = model_reset();
        end
        rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // Holds valid until the model says the sink took the flit (bounded).
    task automatic send(int idx, logic [31:0] f);
        bit took;
        valid_d[idx] = 1'b1;
        data_d[idx]  = f;
        for (int c = 0; c < 8; c++) begin
            took = m[idx].rdy;
            step();
            if (took) break;
        end
        valid_d[idx] = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
            m[i]       = model_reset();
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if ({rx_q[i], err_q[i], flag_q[i], last_q[i], done_q[i], rdy_q[i]} !== 55'd0) begin
                n_fail++;
                $display("FAIL reset_state dut=%0d rx=%0h err=%0h flag=%b last=%b done=%b rdy=%b want all 0",
                         i, rx_q[i], err_q[i], flag_q[i], last_q[i], done_q[i], rdy_q[i]);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b1;
            data_d[i]  = good(16'd1);
        end
        step();
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (rx_q[i] !== 32'd0 || rdy_q[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL first_edge dut=%0d rx=%0d rdy=%b want rx=0 rdy=1", i, rx_q[i], rdy_q[i]);
            end
        end
        step();
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b0;
            n_checks++;
            if (rx_q[i] !== 32'd1) begin
                n_fail++;
                $display("FAIL second_edge_accept dut=%0d rx=%0d want 1", i, rx_q[i]);
            end
        end
    endtask

    task automatic test_in_order();
        apply_reset();
        for (int k = 1; k <= 5; k++) send(0, good(16'(k)));
        n_checks++;
        if (rx_q[0] !== 32'd5 || err_q[0] !== 16'd0 || flag_q[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL in_order rx=%0d err=%0d flag=%b want rx=5 err=0 flag=0", rx_q[0], err_q[0], flag_q[0]);
        end
    endtask

    task automatic test_seq_drop();
        logic [15:0] seqs [4] = '{16'd1, 16'd2, 16'd4, 16'd5};
        apply_reset();
        foreach (seqs[k]) send(0, good(seqs[k]));
        n_checks++;
        if (rx_q[0] !== 32'd4 || err_q[0] !== 16'd1 || last_q[0] !== 4'b1000 || flag_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_drop rx=%0d err=%0d last=%b flag=%b want rx=4 err=1 last=1000 flag=1",
                     rx_q[0], err_q[0], last_q[0], flag_q[0]);
        end
    endtask

    task automatic test_bad_route();
        apply_reset();
        send(0, mk(4'd2, 4'd9, ID_P, 16'd1));
        n_checks++;
        if (last_q[0] !== 4'b0011 || flag_q[0] !== 1'b1 || err_q[0] !== 16'd1) begin
            n_fail++;
            $display("FAIL bad_route last=%b flag=%b err=%0d want last=0011 flag=1 err=1", last_q[0], flag_q[0], err_q[0]);
        end
        send(0, good(16'd2));
        n_checks++;
        if (last_q[0] !== 4'b0011 || err_q[0] !== 16'd1 || rx_q[0] !== 32'd2) begin
            n_fail++;
            $display("FAIL last_err_hold last=%b err=%0d rx=%0d want last=0011 err=1 rx=2", last_q[0], err_q[0], rx_q[0]);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        send(0, good(16'hFFFF));
        send(0, good(16'h0000));
        n_checks++;
        if (rx_q[0] !== 32'd2 || err_q[0] !== 16'd1 || last_q[0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL seq_wrap rx=%0d err=%0d last=%b want rx=2 err=1 last=1000", rx_q[0], err_q[0], last_q[0]);
        end
    endtask

    task automatic test_throttle();
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            send(1, good(16'(k)));
            n_checks++;
            if (rdy_q[1] !== logic'(k % 2)) begin
                n_fail++;
                $display("FAIL throttle_ready accept=%0d rdy=%b want %0d", k, rdy_q[1], k % 2);
            end
        end
        step();
        n_checks++;
        if (rdy_q[1] !== 1'b1 || rx_q[1] !== 32'd6 || err_q[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL throttle_end rdy=%b rx=%0d err=%0d want rdy=1 rx=6 err=0", rdy_q[1], rx_q[1], err_q[1]);
        end
    endtask

    task automatic test_done();
        apply_reset();
        for (int k = 1; k <= 3; k++) send(2, good(16'(k)));
        n_checks++;
        if (done_q[2] !== 1'b1 || rdy_q[2] !== 1'b0 || rx_q[2] !== 32'd3) begin
            n_fail++;
            $display("FAIL done_reached done=%b rdy=%b rx=%0d want done=1 rdy=0 rx=3", done_q[2], rdy_q[2], rx_q[2]);
        end
        valid_d[2] = 1'b1;
        data_d[2]  = mk(4'd1, 4'd2, 8'd9, 16'd77);
        repeat (4) step();
        valid_d[2] = 1'b0;
        n_checks++;
        if (rx_q[2] !== 32'd3 || err_q[2] !== 16'd0 || done_q[2] !== 1'b1 || rdy_q[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_ignores rx=%0d err=%0d done=%b rdy=%b want rx=3 err=0 done=1 rdy=0",
                     rx_q[2], err_q[2], done_q[2], rdy_q[2]);
        end
    endtask

    task automatic test_done_beats_stall();
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            send(3, good(16'(k)));
            n_checks++;
            if (rdy_q[3] !== 1'b0 || done_q[3] !== logic'(k == 3)) begin
                n_fail++;
                $display("FAIL done_vs_stall accept=%0d rdy=%b done=%b want rdy=0 done=%0d", k, rdy_q[3], done_q[3], k == 3);
            end
        end
        repeat (2) step();
        n_checks++;
        if (rdy_q[3] !== 1'b0 || done_q[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL done_sticky rdy=%b done=%b want rdy=0 done=1", rdy_q[3], done_q[3]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < NDUT; i++) snd[i] = 16'd1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                logic [31:0] f;
                int unsigned r;
                f = good(snd[i]);
                r = $urandom_range(0, 19);
                case (r)
                    0: f[31:28] = 4'($urandom);
                    1: f[27:24] = 4'($urandom);
                    2: f[23:16] = 8'($urandom);
                    3: f[15:0]  = snd[i] + 16'd1;
                    4: f[15:0]  = 16'($urandom);
                    default: ;
                endcase
                valid_d[i] = ($urandom_range(0, 3) != 0);
                data_d[i]  = f;
                if (m[i].rdy && valid_d[i]) snd[i] = f[15:0] + 16'd1;
            end
            step();
            for (int i = 0; i < NDUT; i++) begin
                n_checks++;
                if ({rx_q[i], err_q[i], flag_q[i], last_q[i], done_q[i], rdy_q[i]} !==
                    {m[i].rx, 16'(m[i].err), m[i].flag, m[i].last, m[i].done, m[i].rdy}) begin
                    n_fail++;
                    $display("FAIL random cyc=%0d dut=%0d rx=%0d/%0d err=%0d/%0d flag=%b/%b last=%b/%b done=%b/%b rdy=%b/%b (got/want)",
                             c, i, rx_q[i], m[i].rx, err_q[i], m[i].err, flag_q[i], m[i].flag,
                             last_q[i], m[i].last, done_q[i], m[i].done, rdy_q[i], m[i].rdy);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b1;
            data_d[i]  = good(m[i].seq);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < NDUT; i++) m[i] = model_reset();
        #1;
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if ({rx_q[i], err_q[i], flag_q[i], last_q[i], done_q[i], rdy_q[i]} !== 55'd0) begin
                n_fail++;
                $display("FAIL async_reset dut=%0d rx=%0h err=%0h flag=%b last=%b done=%b rdy=%b want all 0",
                         i, rx_q[i], err_q[i], flag_q[i], last_q[i], done_q[i], rdy_q[i]);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < NDUT; i++) valid_d[i] = 1'b0;
        step();
        for (int i = 0; i < NDUT; i++) begin
            n_checks++;
            if (rx_q[i] !== 32'd0 || rdy_q[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_recovery dut=%0d rx=%0d rdy=%b want rx=0 rdy=1", i, rx_q[i], rdy_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            valid_d[i] = 1'b0;
            data_d[i]  = '0;
        end
        test_reset();
        test_in_order();
        test_seq_drop();
        test_bad_route();
        test_wrap();
        test_throttle();
        test_done();
        test_done_beats_stall();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
